// File: rtl/booth_sequencer_if.sv
// rtl/booth_sequencer_if.sv - operand, multiplier and product handshake bundle for booth_sequencer
//
// Purpose: groups every non-clock/reset signal of booth_sequencer.
//   slave  modport: the sequencer itself.
//   master modport: the surroundings (operand source, booth multiplier, product consumer).
// Signals:
//   in_valid/in_ready/in_a/in_b        operand pair handshake (two's complement)
//   mul_in1/mul_in2/mul_start/mul_reset  drive to booth (start 0 = load, 1 = step; reset active-low)
//   mul_result/mul_count               booth product and step counter
//   res_valid/res_ready/res_data       product handshake (signed, 2*WIDTH bits)
//   sync_err                           sticky step-counter mismatch flag
interface booth_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [WIDTH-1:0]     mul_in1;
  logic [WIDTH-1:0]     mul_in2;
  logic                 mul_start;
  logic                 mul_reset;
  logic [2*WIDTH-1:0]   mul_result;
  logic [CNT_W-1:0]     mul_count;
  logic                 res_valid;
  logic                 res_ready;
  logic [2*WIDTH-1:0]   res_data;
  logic                 sync_err;

  modport slave (
    input  in_valid, in_a, in_b, mul_result, mul_count, res_ready,
    output in_ready, mul_in1, mul_in2, mul_start, mul_reset, res_valid, res_data, sync_err
  );

  modport master (
    output in_valid, in_a, in_b, mul_result, mul_count, res_ready,
    input  in_ready, mul_in1, mul_in2, mul_start, mul_reset, res_valid, res_data, sync_err
  );
endinterface

// File: rtl/booth_sequencer.sv
// rtl/booth_sequencer.sv - load/step control stage for the sequential Booth multiplier
//
// Purpose: takes a signed operand pair, has booth load it, issues exactly CYCLES
//   step pulses, then captures the product into a held output register.
//   The booth step counter is checked at capture; a mismatch sets sticky sync_err.
// Ports:
//   clk    rising-edge clock shared with booth
//   reset  asynchronous active-high reset (also holds booth in reset via mul_reset)
//   bus    booth_sequencer_if.slave: operand in, booth drive, product out, sync_err
module booth_sequencer #(
  parameter int WIDTH  = 4,
  parameter int CYCLES = 4,
  parameter int CNT_W  = 2
) (
  input  logic                clk,
  input  logic                reset,
  booth_sequencer_if.slave    bus
);

  localparam int STEP_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(CYCLES - 1);
  // Booth's counter wraps, so after CYCLES steps it reads CYCLES mod 2**CNT_W.
  localparam logic [CNT_W-1:0]  COUNT_DONE = CNT_W'(CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RUN     = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [STEP_W-1:0]    step_cnt;
  logic                 res_valid_q;
  logic [2*WIDTH-1:0]   res_data_q;
  logic                 sync_err_q;
  logic                 in_ready_c;
  logic                 mul_start_c;
  logic                 accept;

  // A new operation is only taken when the product register is free or being
  // drained this cycle, so CAPTURE can never overwrite an unread product.
  always_comb begin
    state_next  = state;
    in_ready_c  = 1'b0;
    mul_start_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = !res_valid_q || bus.res_ready;
        if (bus.in_valid && in_ready_c) state_next = LOAD;
      end
      LOAD: state_next = RUN;
      RUN: begin
        mul_start_c = 1'b1;
        if (step_cnt == LAST_STEP) state_next = CAPTURE;
      end
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign accept = bus.in_valid && in_ready_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      step_cnt    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      sync_err_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (res_valid_q && bus.res_ready) res_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_a <= bus.in_a;
            op_b <= bus.in_b;
          end
        end
        LOAD: step_cnt <= '0;
        RUN:  step_cnt <= step_cnt + STEP_W'(1);
        CAPTURE: begin
          res_data_q  <= bus.mul_result;
          res_valid_q <= 1'b1;
          if (bus.mul_count != COUNT_DONE) sync_err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.mul_start = mul_start_c;
  assign bus.mul_in1   = op_a;
  assign bus.mul_in2   = op_b;
  assign bus.mul_reset = ~reset;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.sync_err  = sync_err_q;

endmodule
